// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM state encoding and
// decade limits used by the top level and by each digit counter.
package bcd_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_OVF  = 2'd3
  } state_e;

  localparam int           BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage : bcd_stopwatch_pkg

// File: rtl/bcd_stopwatch_if.sv
// Control/display bundle between the pulse generator side and the stopwatch.
// The master drives tick and the command pulses; the slave returns the count.
interface bcd_stopwatch_if #(
  parameter int NDIGITS = 4
);

  logic                   tick;
  logic                   start_stop;
  logic                   clear;
  logic [4*NDIGITS-1:0]   digits;
  logic                   running;
  logic                   overflow;

  modport master (
    output tick, start_stop, clear,
    input  digits, running, overflow
  );

  modport slave (
    input  tick, start_stop, clear,
    output digits, running, overflow
  );

endinterface : bcd_stopwatch_if

// File: rtl/bcd_stopwatch_digit.sv
// One decade (bcd_digit) of the stopwatch count: 0..9 with ripple carry out.
// hold_i freezes the digit so a saturated count never wraps to zero.
module bcd_stopwatch_digit
  import bcd_stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             hold_i,
  output logic [BCD_W-1:0] value_o,
  output logic             carry_o
);

  logic [BCD_W-1:0] value_q, value_d;

  // Carry depends only on this decade's increment and value, never on hold_i,
  // so using the last carry as the chain-wide hold forms no combinational loop.
  assign carry_o = inc_i && (value_q == BCD_MAX);
  assign value_o = value_q;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i && !hold_i) begin
      value_d = (value_q == BCD_MAX) ? '0 : value_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule : bcd_stopwatch_digit

// File: rtl/bcd_stopwatch.sv
// Decimal stopwatch: prescaled tick counter in packed BCD with run/stop/clear
// control, saturating at all-9s with an overflow state.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 10,
  parameter int PWIDTH   = 16
) (
  input  logic            clk,
  input  logic            reset,
  bcd_stopwatch_if.slave  bus
);

  localparam logic [PWIDTH-1:0] PMAX = PWIDTH'(PRESCALE - 1);

  state_e                 state_q, state_d;
  logic [PWIDTH-1:0]      presc_q, presc_d;
  logic                   running_q, overflow_q;
  logic                   inc;
  logic                   clr;
  logic                   ovf_hit;
  logic [4*NDIGITS-1:0]   digits_w;

  // A start_stop in the same cycle as a tick wins: the tick is never counted.
  assign inc = (state_q == ST_RUN) && bus.tick && !bus.start_stop &&
               (presc_q == PMAX);

  for (genvar g = 0; g < NDIGITS; g++) begin : gen_dig
    logic c_in;
    logic c_out;

    if (g == 0) begin : gen_first
      assign c_in = inc;
    end else begin : gen_rest
      assign c_in = gen_dig[g-1].c_out;
    end

    bcd_stopwatch_digit u_digit (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (clr),
      .inc_i   (c_in),
      .hold_i  (ovf_hit),
      .value_o (digits_w[g*BCD_W +: BCD_W]),
      .carry_o (c_out)
    );
  end

  // Carry out of the top decade means the count is all-9s and must saturate.
  assign ovf_hit = gen_dig[NDIGITS-1].c_out;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (bus.start_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.start_stop) begin
          state_d = ST_STOP;
        end else if (bus.tick) begin
          presc_d = (presc_q == PMAX) ? '0 : presc_q + PWIDTH'(1);
          if (ovf_hit) state_d = ST_OVF;
        end
      end
      ST_STOP: begin
        if (bus.clear) begin
          state_d = ST_IDLE;
          presc_d = '0;
          clr     = 1'b1;
        end else if (bus.start_stop) begin
          state_d = ST_RUN;
        end
      end
      ST_OVF: begin
        if (bus.clear) begin
          state_d = ST_IDLE;
          presc_d = '0;
          clr     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      running_q  <= (state_d == ST_RUN);
      overflow_q <= (state_d == ST_OVF);
    end
  end

  assign bus.digits   = digits_w;
  assign bus.running  = running_q;
  assign bus.overflow = overflow_q;

endmodule : bcd_stopwatch

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: one instance with PRESCALE=2 and one with
// PRESCALE=1 share clock and reset; expected values are hand-computed.
module tb_bcd_stopwatch;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bcd_stopwatch_if #(.NDIGITS(4)) bus2 ();
  bcd_stopwatch_if #(.NDIGITS(4)) bus1 ();

  bcd_stopwatch #(.NDIGITS(4), .PRESCALE(2), .PWIDTH(16)) u_dut_p2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  bcd_stopwatch #(.NDIGITS(4), .PRESCALE(1), .PWIDTH(16)) u_dut_p1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are held for one cycle;
  // outputs are sampled 1 time unit after the edge that consumed them.
  task automatic step2(input logic t, input logic s, input logic c);
    bus2.tick = t; bus2.start_stop = s; bus2.clear = c;
    @(posedge clk); #1;
    bus2.tick = 1'b0; bus2.start_stop = 1'b0; bus2.clear = 1'b0;
  endtask

  task automatic step1(input logic t, input logic s, input logic c);
    bus1.tick = t; bus1.start_stop = s; bus1.clear = c;
    @(posedge clk); #1;
    bus1.tick = 1'b0; bus1.start_stop = 1'b0; bus1.clear = 1'b0;
  endtask

  task automatic ticks2(input int n);
    repeat (n) step2(1'b1, 1'b0, 1'b0);
  endtask

  task automatic ticks1(input int n);
    repeat (n) step1(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus2.tick = 1'b0; bus2.start_stop = 1'b0; bus2.clear = 1'b0;
    bus1.tick = 1'b0; bus1.start_stop = 1'b0; bus1.clear = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_digits", bus2.digits, 16'h0000);
    check("rst_running", bus2.running, 1'b0);
    check("rst_overflow", bus2.overflow, 1'b0);

    // Reset mid-RUN at 0123 (PRESCALE=1 instance)
    step1(1'b0, 1'b1, 1'b0);
    ticks1(123);
    check("pre_rst_count", bus1.digits, 16'h0123);
    check("pre_rst_running", bus1.running, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_digits", bus1.digits, 16'h0000);
    check("async_rst_running", bus1.running, 1'b0);
    check("async_rst_overflow", bus1.overflow, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    ticks1(3);
    check("post_rst_idle_digits", bus1.digits, 16'h0000);
    check("post_rst_idle_running", bus1.running, 1'b0);

    // PRESCALE=2: 10 ticks -> 0005, 11th leaves 0005
    step2(1'b0, 1'b1, 1'b0);
    check("p2_start_running", bus2.running, 1'b1);
    ticks2(10);
    check("p2_10_ticks", bus2.digits, 16'h0005);
    check("p2_10_running", bus2.running, 1'b1);
    ticks2(1);
    check("p2_11_ticks", bus2.digits, 16'h0005);

    // 85 ticks total -> count 42 with prescaler at 1
    ticks2(74);
    check("p2_85_ticks", bus2.digits, 16'h0042);
    step2(1'b0, 1'b1, 1'b0);
    check("pause_running", bus2.running, 1'b0);
    ticks2(5);
    check("pause_held", bus2.digits, 16'h0042);
    step2(1'b0, 1'b1, 1'b0);
    check("resume_running", bus2.running, 1'b1);
    ticks2(1);
    check("resume_partial_kept", bus2.digits, 16'h0043);

    // Simultaneous commands
    step2(1'b1, 1'b1, 1'b0);
    check("run_tick_ss_digits", bus2.digits, 16'h0043);
    check("run_tick_ss_running", bus2.running, 1'b0);
    step2(1'b0, 1'b1, 1'b1);
    check("stop_clr_ss_digits", bus2.digits, 16'h0000);
    check("stop_clr_ss_running", bus2.running, 1'b0);
    ticks2(2);
    check("idle_ignores_tick", bus2.digits, 16'h0000);
    step2(1'b1, 1'b1, 1'b0);
    check("idle_tick_ss_running", bus2.running, 1'b1);
    check("idle_tick_ss_digits", bus2.digits, 16'h0000);
    ticks2(1);
    check("first_tick_partial", bus2.digits, 16'h0000);
    ticks2(1);
    check("second_tick_count", bus2.digits, 16'h0001);

    // Carry ripple (PRESCALE=1, currently IDLE at 0000)
    step1(1'b0, 1'b1, 1'b0);
    ticks1(99);
    check("ripple_0099", bus1.digits, 16'h0099);
    ticks1(1);
    check("ripple_0100", bus1.digits, 16'h0100);
    ticks1(899);
    check("ripple_0999", bus1.digits, 16'h0999);
    ticks1(1);
    check("ripple_1000", bus1.digits, 16'h1000);

    // Saturation
    ticks1(8999);
    check("sat_9999_run", bus1.digits, 16'h9999);
    check("sat_pre_overflow", bus1.overflow, 1'b0);
    ticks1(1);
    check("sat_digits", bus1.digits, 16'h9999);
    check("sat_overflow", bus1.overflow, 1'b1);
    check("sat_running", bus1.running, 1'b0);
    step1(1'b0, 1'b1, 1'b0);
    check("ovf_ss_ignored_ovf", bus1.overflow, 1'b1);
    check("ovf_ss_ignored_run", bus1.running, 1'b0);
    ticks1(2);
    check("ovf_tick_held", bus1.digits, 16'h9999);
    step1(1'b0, 1'b0, 1'b1);
    check("ovf_clr_digits", bus1.digits, 16'h0000);
    check("ovf_clr_overflow", bus1.overflow, 1'b0);
    check("ovf_clr_running", bus1.running, 1'b0);
    ticks1(1);
    check("ovf_clr_idle", bus1.digits, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd_stopwatch

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
Decimal stopwatch/counter that consumes the single-cycle periodic tick produced by the team's pulse generator, one stage downstream of it. Counts qualified ticks in packed BCD under start/stop/clear control and saturates with an overflow flag. Output drives the display driver stage (digit multiplexer / 7-seg decoder).

Parameters:
NDIGITS, 4, number of BCD decades; digits bus width is 4*NDIGITS
PRESCALE, 10, ticks per least-significant-digit increment; legal range 1..65535
PWIDTH, 16, prescaler counter width; must hold PRESCALE-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state
tick  input  1  one-cycle enable pulse from the pulse generator
start_stop  input  1  one-cycle command pulse; toggles run/stop
clear  input  1  one-cycle command pulse; zero count when not running
digits  output  4*NDIGITS  packed BCD count, digit 0 in bits [3:0]
running  output  1  high while in RUN
overflow  output  1  high while in OVF (count saturated at all-9s)

Behaviour:
- Reset: state IDLE, digits all 0, prescaler 0, running 0, overflow 0. Reset acts immediately, including mid-count.
- All outputs registered; no combinational input-to-output path.
- States: IDLE (count zero, stopped), RUN, STOP (paused, count held), OVF (saturated).
- IDLE: start_stop -> RUN; clear has no effect; tick ignored.
- RUN: start_stop -> STOP; clear ignored; tick advances prescaler.
- STOP: clear -> IDLE (digits 0, prescaler 0); start_stop -> RUN; clear and start_stop together -> clear wins, IDLE.
- OVF: clear -> IDLE; start_stop ignored; digits held at all-9s.
- Prescaler: counts ticks only in RUN. On tick with prescaler == PRESCALE-1, prescaler -> 0 and count increments; otherwise prescaler +1. Held in STOP (partial interval preserved across pause); zeroed on clear or entry to IDLE. PRESCALE=1 increments on every tick.
- Increment: decimal ripple; digit 9 -> 0 with carry to next decade; digits never hold 0xA-0xF.
- Increment when count is all-9s: digits stay all-9s, state -> OVF, overflow=1 on the next cycle.
- Latency: digits, running and overflow change on the clock edge where the qualifying input is sampled; visible one cycle after the input pulse.
- tick and start_stop in the same cycle in RUN: stop takes effect; tick not counted.
- tick and start_stop in the same cycle in STOP or IDLE: enter RUN; tick not counted. Counting starts with the next tick.
- start_stop or clear held high for several cycles: each high cycle is a separate command. Upstream delivers single-cycle pulses.

Decomposition:
- Shared package: state encoding (IDLE, RUN, STOP, OVF, 2-bit), BCD_W=4, BCD_MAX=9.
- Sub-module bcd_digit: one decade counter with clk, reset, clr, inc_in, value[3:0], carry_out (inc_in && value==9). Instantiated NDIGITS times in a ripple chain. Top-level carry_out of the last digit drives the OVF transition and suppresses the wrap-to-zero.

Test Plan:
- Reset mid-RUN at count 0123 -> digits=0000, running=0, overflow=0 immediately; stays IDLE with ticks applied.
- PRESCALE=2: start_stop, then 10 ticks -> digits 0005, running=1; an 11th tick leaves prescaler at 1 and digits at 0005.
- Carry ripple: preload to 0099 in RUN (PRESCALE=1), one tick -> 0100; at 0999, one tick -> 1000.
- Pause: at 0042 with prescaler=1 (PRESCALE=2), start_stop -> STOP; 5 ticks -> still 0042. start_stop, then 1 tick -> 0043.
- Saturation (PRESCALE=1): count at 9999 in RUN, one tick -> digits 9999, overflow=1, running=0. start_stop ignored; clear -> 0000, overflow=0, IDLE.
- Simultaneous: in RUN, tick and start_stop in the same cycle -> STOP, count unchanged. In STOP, clear and start_stop in the same cycle -> IDLE, digits 0000, running=0.
